// File: rtl/buf_ld_ctrl.sv
// -----------------------------------------------------------------------------
// buf_ld_ctrl -- ping-pong buffer load controller
//
// Accepts a job of cfg_num_tiles tiles of cfg_len words each from a
// valid/ready load stream and writes each tile into alternating banks of a
// ping-pong buffer. A bank is flagged full once its last write has committed;
// the execute side frees it again with an ex_rel pulse.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   cfg_start             one-cycle job start pulse (ignored while busy)
//   cfg_len               words per tile, valid range 1..2^BUF_LD_ADDR_WIDTH
//   cfg_num_tiles         tiles per job (0 = empty job, immediate ld_done)
//   s_valid/s_ready/s_data load stream (s_ready is combinational)
//   buf_ld_wr_en/_sel/_addr/_data  registered buffer write port
//   ex_rel, ex_rel_bank   one-cycle bank release from the execute side
//   bank_full             per-bank ready-for-execute flags
//   busy, ld_done, ld_err job active, one-cycle job completion, sticky error
//
// Optional feature: define BUF_LD_ERR_CHK_EN to make ld_err record ignored
// starts (busy or bad length) and releases of a bank that is not full.
// Without it ld_err is tied to 0.
// -----------------------------------------------------------------------------
module buf_ld_ctrl #(
  parameter int BUF_LD_ADDR_WIDTH = 10,
  parameter int BUF_LD_DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_start,
  input  logic [BUF_LD_ADDR_WIDTH:0]   cfg_len,
  input  logic [15:0]                  cfg_num_tiles,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [BUF_LD_DATA_WIDTH-1:0] s_data,
  output logic                         buf_ld_wr_en,
  output logic                         buf_ld_sel,
  output logic [BUF_LD_ADDR_WIDTH-1:0] buf_ld_addr,
  output logic [BUF_LD_DATA_WIDTH-1:0] buf_ld_data,
  input  logic                         ex_rel,
  input  logic                         ex_rel_bank,
  output logic [1:0]                   bank_full,
  output logic                         busy,
  output logic                         ld_done,
  output logic                         ld_err
);

  localparam int AW = BUF_LD_ADDR_WIDTH;
  localparam int DW = BUF_LD_DATA_WIDTH;
  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic          cur_sel_q, cur_sel_d;
  logic [AW:0]   word_cnt_q, word_cnt_d;
  logic [AW:0]   len_q, len_d;
  logic [15:0]   tile_cnt_q, tile_cnt_d;   // tiles still to load, incl. current
  logic          set_pend_q, set_pend_d;   // last write of a tile is on the port
  logic          done_pend_q, done_pend_d;
  logic          ld_done_q, ld_done_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic          wr_en_q;
  logic          wr_sel_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;

  logic hs, last_word, len_ok, rel_ok;

  assign s_ready   = (state_q == S_LOAD) && !bank_full_q[cur_sel_q];
  assign hs        = s_valid && s_ready;
  assign last_word = (word_cnt_q == len_q - ONE);
  assign len_ok    = (cfg_len != '0) && (cfg_len <= LEN_MAX);
  assign rel_ok    = ex_rel && bank_full_q[ex_rel_bank];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel_q;
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    tile_cnt_d  = tile_cnt_q;
    set_pend_d  = 1'b0;
    done_pend_d = 1'b0;
    ld_done_d   = done_pend_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start && len_ok) begin
          if (cfg_num_tiles != '0) begin
            state_d    = S_LOAD;
            len_d      = cfg_len;
            tile_cnt_d = cfg_num_tiles;
            word_cnt_d = '0;
          end else begin
            ld_done_d  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (hs) begin
          if (last_word) begin
            word_cnt_d = '0;
            cur_sel_d  = ~cur_sel_q;
            set_pend_d = 1'b1;
            if (tile_cnt_q == 16'd1) begin
              state_d     = S_IDLE;
              tile_cnt_d  = '0;
              done_pend_d = 1'b1;
            end else begin
              tile_cnt_d = tile_cnt_q - 16'd1;
              state_d    = bank_full_q[~cur_sel_q] ? S_WAIT : S_LOAD;
            end
          end else begin
            word_cnt_d = word_cnt_q + ONE;
          end
        end else if (bank_full_q[cur_sel_q]) begin
          // Covers a job started on a full bank and a bank whose full flag
          // landed just after the tile-end decision (very short tiles).
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bank_full_q[cur_sel_q]) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A release only acts on a full bank; the full flag is set from the bank
  // currently on the write port, one cycle after the tile's last handshake.
  always_comb begin
    bank_full_d = bank_full_q;
    if (rel_ok)     bank_full_d[ex_rel_bank] = 1'b0;
    if (set_pend_q) bank_full_d[wr_sel_q]    = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  // NOTE: every register, including the write-port data path, is reset so the
  // port reads all-zero immediately when rst_n asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_sel_q   <= 1'b0;
      word_cnt_q  <= '0;
      len_q       <= '0;
      tile_cnt_q  <= '0;
      set_pend_q  <= 1'b0;
      done_pend_q <= 1'b0;
      ld_done_q   <= 1'b0;
      bank_full_q <= 2'b00;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      tile_cnt_q  <= tile_cnt_d;
      set_pend_q  <= set_pend_d;
      done_pend_q <= done_pend_d;
      ld_done_q   <= ld_done_d;
      bank_full_q <= bank_full_d;
      wr_en_q     <= hs;
      if (hs) begin
        wr_sel_q  <= cur_sel_q;
        wr_addr_q <= word_cnt_q[AW-1:0];
        wr_data_q <= s_data;
      end
    end
  end

`ifdef BUF_LD_ERR_CHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((cfg_start && ((state_q != S_IDLE) || !len_ok)) ||
                 (ex_rel && !bank_full_q[ex_rel_bank])) begin
      err_q <= 1'b1;
    end
  end
  assign ld_err = err_q;
`else
  assign ld_err = 1'b0;
`endif

  assign buf_ld_wr_en = wr_en_q;
  assign buf_ld_sel   = wr_sel_q;
  assign buf_ld_addr  = wr_addr_q;
  assign buf_ld_data  = wr_data_q;
  assign bank_full    = bank_full_q;
  assign busy         = (state_q != S_IDLE);
  assign ld_done      = ld_done_q;

endmodule

// File: tb/tb_buf_ld_ctrl.sv
module tb_buf_ld_ctrl;

  localparam int AW = 10;
  localparam int DW = 8;
`ifdef BUF_LD_ERR_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [AW:0]   cfg_len;
  logic [15:0]   cfg_num_tiles;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          buf_ld_wr_en;
  logic          buf_ld_sel;
  logic [AW-1:0] buf_ld_addr;
  logic [DW-1:0] buf_ld_data;
  logic          ex_rel;
  logic          ex_rel_bank;
  logic [1:0]    bank_full;
  logic          busy;
  logic          ld_done;
  logic          ld_err;

  buf_ld_ctrl #(.BUF_LD_ADDR_WIDTH(AW), .BUF_LD_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_num_tiles(cfg_num_tiles),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .buf_ld_wr_en(buf_ld_wr_en), .buf_ld_sel(buf_ld_sel),
    .buf_ld_addr(buf_ld_addr), .buf_ld_data(buf_ld_data),
    .ex_rel(ex_rel), .ex_rel_bank(ex_rel_bank),
    .bank_full(bank_full), .busy(busy), .ld_done(ld_done), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int hs_first, hs_last;
  logic [AW+DW:0] exp_q[$];   // {sel, addr, data}

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && buf_ld_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got sel=%0d addr=%0d data=%0h, expected none",
                 buf_ld_sel, buf_ld_addr, buf_ld_data);
      end else begin
        check("write{sel,addr,data}", 32'({buf_ld_sel, buf_ld_addr, buf_ld_data}),
              32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int len, input int tiles);
    cfg_len       = (AW+1)'(len);
    cfg_num_tiles = 16'(tiles);
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
  endtask

  task automatic release_bank(input logic b);
    ex_rel      = 1'b1;
    ex_rel_bank = b;
    tick();
    ex_rel      = 1'b0;
  endtask

  // Drive n words with s_valid held; word i is expected at bank
  // sel0 ^ (i/len) and address i % len. Returns in the cycle after the last
  // handshake.
  task automatic stream(input int n, input int len, input logic sel0,
                        input logic [DW-1:0] d0);
    logic ok;
    logic sel;
    for (int i = 0; i < n; i++) begin
      s_data  = d0 + DW'(i);
      s_valid = 1'b1;
      ok      = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (s_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        n_cmp++;
        n_err++;
        $display("FAIL stream_timeout: got no s_ready for word %0d, expected ready within 50 cycles", i);
        s_valid = 1'b0;
        return;
      end
      sel = sel0 ^ 1'((i / len) % 2);
      exp_q.push_back({sel, AW'(i % len), s_data});
      if (i == 0) hs_first = cyc;
      hs_last = cyc;
      tick();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_len = '0; cfg_num_tiles = '0;
    s_valid = 1'b0; s_data = '0; ex_rel = 1'b0; ex_rel_bank = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'({buf_ld_wr_en, buf_ld_sel, buf_ld_addr, buf_ld_data,
                                s_ready, busy, ld_done, ld_err, bank_full}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Two tiles of 4 words, stream held valid.
    start(4, 2);
    check("job1_busy", 32'(busy), 32'd1);
    stream(8, 4, 1'b0, 8'h10);
    check("job1_no_gaps", 32'(hs_last - hs_first), 32'd7);
    check("job1_bank_full_n1", 32'(bank_full), 32'b01);
    check("job1_done_n1", 32'(ld_done), 32'd0);
    tick();
    check("job1_bank_full_n2", 32'(bank_full), 32'b11);
    check("job1_done_n2", 32'(ld_done), 32'd1);
    tick();
    check("job1_done_n3", 32'(ld_done), 32'd0);
    check("job1_idle", 32'(busy), 32'd0);

    // Both banks full: job waits until bank 0 is released.
    start(2, 1);
    check("wait_ready_s1", 32'(s_ready), 32'd0);
    tick();
    check("wait_ready_s2", 32'({busy, s_ready}), 32'b10);
    release_bank(1'b0);
    check("wait_ready_m1", 32'(s_ready), 32'd0);
    tick();
    check("wait_ready_m2", 32'(s_ready), 32'd1);
    stream(2, 2, 1'b0, 8'h40);
    tick();
    check("wait_bank_full", 32'(bank_full), 32'b11);
    check("wait_done", 32'(ld_done), 32'd1);

    // Release of bank 1 in the cycle its full flag is being set.
    release_bank(1'b1);
    check("rel1_bank_full", 32'(bank_full), 32'b01);
    start(1, 1);
    stream(1, 1, 1'b1, 8'h5a);
    release_bank(1'b1);
    check("race_bank_full", 32'(bank_full), 32'b11);
    check("race_err", 32'(ld_err), 32'(ERR_EXP));

    // Reset mid-tile, then restart from bank 0 address 0.
    release_bank(1'b0);
    start(4, 1);
    stream(2, 4, 1'b0, 8'h80);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_outputs", 32'({buf_ld_wr_en, buf_ld_sel, buf_ld_addr, buf_ld_data,
                                   s_ready, busy, ld_done, ld_err, bank_full}), 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_quiet", 32'({buf_ld_wr_en, busy, s_ready}), 32'd0);
    start(4, 1);
    stream(4, 4, 1'b0, 8'h90);
    tick();
    check("restart_bank_full", 32'(bank_full), 32'b01);
    check("restart_done", 32'(ld_done), 32'd1);
    tick();

    // Empty job and invalid lengths.
    start(4, 0);
    check("zero_tiles_done", 32'({busy, ld_done}), 32'b01);
    tick();
    check("zero_tiles_done_end", 32'(ld_done), 32'd0);
    start(0, 1);
    check("len0_ignored", 32'({busy, s_ready}), 32'd0);
    tick();
    check("len0_no_done", 32'(ld_done), 32'd0);
    check("len0_err", 32'(ld_err), 32'(ERR_EXP));
    start(1025, 1);
    check("len_over_ignored", 32'(busy), 32'd0);
    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
